fetch_queue: RTL and testbench

- Parametrised instruction-fetch stage that replaces the bare program_counter/pc_adder/inst_mem path.
- Owns the fetch PC and issues requests to instruction memory over a req/ack handshake, so multi-cycle memories are supported.
- Buffers fetched words with their PC+STEP value in a DEPTH-entry FIFO that feeds if_id.
- Supports decode-side backpressure and a redirect flush on branch, jump or jr.

---
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Request/acknowledge link between the instruction-fetch queue and
//   instruction memory.
//
//   imem_req   fetch request valid (driven by the fetch stage)
//   imem_addr  fetch address (driven by the fetch stage)
//   imem_ack   memory accepts the request; imem_data is valid this cycle
//   imem_data  returned instruction word
//
//   master : fetch-stage side (drives req/addr, samples ack/data)
//   slave  : memory side
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage. Owns the fetch PC, requests words from
//   instruction memory over a req/ack handshake (so the memory may take any
//   number of cycles), and buffers returned words together with their
//   PC+PC_STEP in a DEPTH-entry FIFO that feeds the if/id register.
//   A redirect (branch/jump/jr) flushes the FIFO and reloads the fetch PC.
//
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   redirect     flush queue and load redirect_pc
//   redirect_pc  new fetch target
//   imem         memory request/ack link (master side)
//   deq          decode consumes the head entry
//   inst_valid   head entry valid
//   inst_out     head instruction, 0 when empty
//   pc_out       head PC+PC_STEP, 0 when empty
//   count        occupied entries
//   fetch_pc     current fetch PC
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    fetch_queue_if.master                imem,
    input  logic                         deq,
    output logic                         inst_valid,
    output logic [DATA_W-1:0]            inst_out,
    output logic [ADDR_W-1:0]            pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ADDR_W-1:0]            fetch_pc
);

    // A 1-entry queue still needs a 1-bit pointer; it simply never leaves 0.
    localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0]  STEP     = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;

    // Payload storage carries no reset; the head outputs are gated by
    // head_valid so stale or uninitialised contents never leak out.
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] npc_mem_q  [DEPTH];

    logic req;
    logic push;
    logic pop;
    logic head_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Request is withdrawn during reset and redirect so nothing fetched from
    // the stale path is ever accepted; push therefore already excludes both.
    assign req        = !reset && !redirect && (count_q < CNT_FULL);
    assign push       = req && imem.imem_ack;
    assign head_valid = (count_q != '0);
    assign pop        = deq && head_valid && !redirect;

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = ptr_inc(wr_ptr_q);
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: async reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage: written on accepted transfer only.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem.imem_data;
            npc_mem_q[wr_ptr_q]  <= fetch_pc_q + STEP;
        end
    end

    assign inst_valid = head_valid;
    assign inst_out   = head_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign pc_out     = head_valid ? npc_mem_q[rd_ptr_q]  : '0;
    assign count      = count_q;
    assign fetch_pc   = fetch_pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. Two instances: A (DEPTH=4,
//   RESET_PC=0x100) and B (DEPTH=1, RESET_PC=0xFFFFFFF8). Memory returns
//   the request address as the instruction word, so expected values follow
//   directly from the fetch PC sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A ----------------
    logic        rst_a, redir_a, deq_a, ack_a;
    logic [31:0] redir_pc_a;
    logic        valid_a;
    logic [31:0] inst_a, pcout_a, fpc_a;
    logic [2:0]  cnt_a;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    assign ifa.imem_ack  = ack_a;
    assign ifa.imem_data = ifa.imem_addr;

    fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4),
        .RESET_PC(32'h0000_0100), .PC_STEP(4)
    ) dut_a (
        .clock(clk), .reset(rst_a), .redirect(redir_a), .redirect_pc(redir_pc_a),
        .imem(ifa), .deq(deq_a), .inst_valid(valid_a), .inst_out(inst_a),
        .pc_out(pcout_a), .count(cnt_a), .fetch_pc(fpc_a)
    );

    // ---------------- instance B ----------------
    logic        rst_b, redir_b, deq_b, ack_b;
    logic [31:0] redir_pc_b;
    logic        valid_b;
    logic [31:0] inst_b, pcout_b, fpc_b;
    logic [0:0]  cnt_b;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
    assign ifb.imem_ack  = ack_b;
    assign ifb.imem_data = ifb.imem_addr;

    fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(1),
        .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
    ) dut_b (
        .clock(clk), .reset(rst_b), .redirect(redir_b), .redirect_pc(redir_pc_b),
        .imem(ifb), .deq(deq_b), .inst_valid(valid_b), .inst_out(inst_b),
        .pc_out(pcout_b), .count(cnt_b), .fetch_pc(fpc_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset A, then release it with the given deq/ack levels.
    task automatic restart_a(input logic d, input logic a);
        rst_a = 1'b1;
        deq_a = d;
        ack_a = a;
        tick();
        rst_a = 1'b0;
        #1;
    endtask

    // DEPTH=1 expectations, one row per cycle after reset release.
    logic [31:0] b_addr  [6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
    logic        b_valid [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] b_inst  [6] = '{32'h0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0};
    logic [31:0] b_pcout [6] = '{32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 32'h0, 32'h4};

    initial begin
        logic [31:0] exp_addr;
        logic        prev_ack;

        rst_a = 1'b1; redir_a = 1'b0; redir_pc_a = '0; deq_a = 1'b1; ack_a = 1'b1;
        rst_b = 1'b1; redir_b = 1'b0; redir_pc_b = '0; deq_b = 1'b0; ack_b = 1'b1;
        #1;

        // Reset state
        chk("rst_req",   ifa.imem_req, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_inst",  inst_a, 0);
        chk("rst_pcout", pcout_a, 0);
        chk("rst_fpc",   fpc_a, 32'h100);

        // Streaming: ack=1, deq=1 -> one word per cycle, count stays 1
        tick();
        rst_a = 1'b0;
        #1;
        chk("str_req0",  ifa.imem_req, 1);
        chk("str_addr0", ifa.imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("str_valid", valid_a, 1);
            chk("str_inst",  inst_a, 32'h100 + 4*i);
            chk("str_pcout", pcout_a, 32'h104 + 4*i);
            chk("str_count", cnt_a, 1);
        end

        // Fill to full with deq=0, then a single pop
        restart_a(1'b0, 1'b1);
        chk("fill_req0", ifa.imem_req, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("fill_count", cnt_a, i);
        end
        chk("full_req",  ifa.imem_req, 0);
        chk("full_fpc",  fpc_a, 32'h110);
        chk("full_head", inst_a, 32'h100);
        deq_a = 1'b1;
        tick();
        deq_a = 1'b0;
        #1;
        chk("pop_count", cnt_a, 3);
        chk("pop_req",   ifa.imem_req, 1);
        chk("pop_addr",  ifa.imem_addr, 32'h110);
        chk("pop_head",  inst_a, 32'h104);

        // Slow memory: ack every third cycle, deq=1
        restart_a(1'b1, 1'b0);
        exp_addr = 32'h100;
        prev_ack = 1'b0;
        for (int k = 0; k < 9; k++) begin
            ack_a = (k % 3 == 2);
            #1;
            chk("slow_addr",  ifa.imem_addr, exp_addr);
            chk("slow_req",   ifa.imem_req, 1);
            chk("slow_valid", valid_a, prev_ack);
            if (prev_ack) chk("slow_inst", inst_a, exp_addr - 4);
            tick();
            prev_ack = ack_a;
            if (ack_a) exp_addr = exp_addr + 4;
        end
        ack_a = 1'b0;

        // Redirect with 3 queued entries, coincident with ack
        restart_a(1'b0, 1'b1);
        tick(); tick(); tick();
        chk("rd_pre_count", cnt_a, 3);
        redir_a = 1'b1;
        redir_pc_a = 32'h400;
        #1;
        chk("rd_req_low", ifa.imem_req, 0);
        tick();
        redir_a = 1'b0;
        #1;
        chk("rd_count", cnt_a, 0);
        chk("rd_valid", valid_a, 0);
        chk("rd_inst",  inst_a, 0);
        chk("rd_addr",  ifa.imem_addr, 32'h400);
        chk("rd_req",   ifa.imem_req, 1);
        deq_a = 1'b1;
        tick();
        chk("rd_first_inst",  inst_a, 32'h400);
        chk("rd_first_pcout", pcout_a, 32'h404);
        // Back-to-back redirects: last wins
        redir_a = 1'b1;
        redir_pc_a = 32'h500;
        tick();
        redir_pc_a = 32'h600;
        tick();
        redir_a = 1'b0;
        #1;
        chk("rd2_fpc",   fpc_a, 32'h600);
        chk("rd2_count", cnt_a, 0);

        // Asynchronous reset mid-cycle with count=2 and a pending request
        restart_a(1'b0, 1'b1);
        tick(); tick();
        ack_a = 1'b0;
        #1;
        chk("ar_pre_count", cnt_a, 2);
        chk("ar_pre_req",   ifa.imem_req, 1);
        #2;
        rst_a = 1'b1;
        #1;
        chk("ar_count", cnt_a, 0);
        chk("ar_valid", valid_a, 0);
        chk("ar_inst",  inst_a, 0);
        chk("ar_pcout", pcout_a, 0);
        chk("ar_req",   ifa.imem_req, 0);
        chk("ar_fpc",   fpc_a, 32'h100);
        tick();
        rst_a = 1'b0;
        ack_a = 1'b1;
        #1;
        chk("ar_restart_addr", ifa.imem_addr, 32'h100);
        chk("ar_restart_req",  ifa.imem_req, 1);

        // DEPTH=1 with toggling deq and PC wrap
        rst_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            deq_b = (k % 2 == 1);
            #1;
            chk("d1_valid", valid_b, b_valid[k]);
            chk("d1_req",   ifb.imem_req, !b_valid[k]);
            chk("d1_addr",  ifb.imem_addr, b_addr[k]);
            chk("d1_inst",  inst_b, b_inst[k]);
            chk("d1_pcout", pcout_b, b_pcout[k]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
